// File: rtl/credit_avail_vc_if.sv
// Flit/credit handshake bundle between a sender and its per-VC credit tracker.
// The master drives traffic; the slave (the tracker) reports credit state.
interface credit_avail_vc_if #(
  parameter int NUM_CH   = 2,
  parameter int CNT_BITS = 3
);
  logic [NUM_CH-1:0]          valid;
  logic [NUM_CH-1:0]          yummy;
  logic [NUM_CH-1:0]          spc_avail;
  logic [NUM_CH-1:0]          low_water;
  logic [NUM_CH*CNT_BITS-1:0] credit_cnt;
  logic [NUM_CH-1:0]          err_ovf;
  logic [NUM_CH-1:0]          err_udf;

  modport master (
    output valid, yummy,
    input  spc_avail, low_water, credit_cnt, err_ovf, err_udf
  );

  modport slave (
    input  valid, yummy,
    output spc_avail, low_water, credit_cnt, err_ovf, err_udf
  );
endinterface

// File: rtl/credit_avail_vc.sv
// Per-virtual-channel credit tracker: registered send/return events feed a
// clamped credit counter; all outputs come from flops only.

module credit_avail_vc_lane #(
  parameter int BUFFER_SIZE = 4,
  parameter int CNT_BITS    = 3,
  parameter int LOW_MARK    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid,
  input  logic                yummy,
  output logic                spc_avail,
  output logic                low_water,
  output logic [CNT_BITS-1:0] credit_cnt,
  output logic                err_ovf,
  output logic                err_udf
);
  localparam int            W     = CNT_BITS + 1;
  localparam logic [W-1:0]  BUF_W = W'(BUFFER_SIZE);
  localparam logic [W-1:0]  LOW_W = W'(LOW_MARK);

  logic [CNT_BITS-1:0] count_q, count_d;
  logic                valid_q, valid_d;
  logic                yummy_q, yummy_d;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;
  logic [W-1:0]        sum, eff;

  // One extra bit keeps count+1 exact; the zero check avoids wrapping below 0.
  always_comb begin
    sum = {1'b0, count_q} + {{CNT_BITS{1'b0}}, yummy_q};
    eff = (valid_q && sum == '0) ? '0 : sum - {{CNT_BITS{1'b0}}, valid_q};
    if (eff > BUF_W) eff = BUF_W;
  end

  always_comb begin
    count_d = eff[CNT_BITS-1:0];
    valid_d = valid;
    yummy_d = yummy;
    ovf_d   = ovf_q || (count_q == BUF_W[CNT_BITS-1:0] && yummy_q && !valid_q);
    udf_d   = udf_q || (count_q == '0 && valid_q && !yummy_q);
    if (reset) begin
      count_d = BUF_W[CNT_BITS-1:0];
      valid_d = 1'b0;
      yummy_d = 1'b0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
    valid_q <= valid_d;
    yummy_q <= yummy_d;
    ovf_q   <= ovf_d;
    udf_q   <= udf_d;
  end

  assign spc_avail  = (eff != '0);
  assign low_water  = (eff <= LOW_W);
  assign credit_cnt = eff[CNT_BITS-1:0];
  assign err_ovf    = ovf_q;
  assign err_udf    = udf_q;
endmodule

module credit_avail_vc #(
  parameter int NUM_CH      = 2,
  parameter int BUFFER_SIZE = 4,
  parameter int CNT_BITS    = 3,
  parameter int LOW_MARK    = 1
) (
  input logic               clk,
  input logic               reset,
  credit_avail_vc_if.slave  bus
);
  logic [NUM_CH-1:0]               spc_avail;
  logic [NUM_CH-1:0]               low_water;
  logic [NUM_CH-1:0][CNT_BITS-1:0] credit_cnt;
  logic [NUM_CH-1:0]               err_ovf;
  logic [NUM_CH-1:0]               err_udf;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    credit_avail_vc_lane #(
      .BUFFER_SIZE (BUFFER_SIZE),
      .CNT_BITS    (CNT_BITS),
      .LOW_MARK    (LOW_MARK)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .valid      (bus.valid[i]),
      .yummy      (bus.yummy[i]),
      .spc_avail  (spc_avail[i]),
      .low_water  (low_water[i]),
      .credit_cnt (credit_cnt[i]),
      .err_ovf    (err_ovf[i]),
      .err_udf    (err_udf[i])
    );
  end

  assign bus.spc_avail  = spc_avail;
  assign bus.low_water  = low_water;
  assign bus.credit_cnt = credit_cnt;
  assign bus.err_ovf    = err_ovf;
  assign bus.err_udf    = err_udf;
endmodule

// File: tb/tb_credit_avail_vc.sv
// Bench: directed vector table on a default-sized tracker, then random legal
// traffic on a 4-channel tracker checked against a credit-accounting model.
module tb_credit_avail_vc;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  credit_avail_vc_if #(.NUM_CH(2), .CNT_BITS(3)) bus_d ();
  credit_avail_vc_if #(.NUM_CH(4), .CNT_BITS(3)) bus_r ();

  credit_avail_vc dut_d (.clk(clk), .reset(reset), .bus(bus_d.slave));
  credit_avail_vc #(.NUM_CH(4), .BUFFER_SIZE(7), .CNT_BITS(3), .LOW_MARK(2))
    dut_r (.clk(clk), .reset(reset), .bus(bus_r.slave));

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] v, y;
    int         c0, c1;
    logic [1:0] spc, low, ovf, udf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [1:0] v, input logic [1:0] y,
                     input int c0, input int c1, input logic [1:0] spc,
                     input logic [1:0] low, input logic [1:0] ovf, input logic [1:0] udf);
    vec_t e;
    e.rst = rst; e.v = v; e.y = y; e.c0 = c0; e.c1 = c1;
    e.spc = spc; e.low = low; e.ovf = ovf; e.udf = udf;
    tbl.push_back(e);
  endtask

  // Random-phase model: credits = BUFFER_SIZE - flits captured + returns captured.
  int          sent[4], ret[4];
  int          due[4][$];
  logic [3:0]  vdrv, ydrv;

  task automatic check_rand(input int cyc);
    for (int i = 0; i < 4; i++) begin
      int exp, act;
      exp = 7 - sent[i] + ret[i];
      act = int'((bus_r.credit_cnt >> (3 * i)) & 12'h7);
      chk($sformatf("rand c%0d ch%0d cnt", cyc, i), act, exp);
      chk($sformatf("rand c%0d ch%0d flags", cyc, i),
          {bus_r.spc_avail[i], bus_r.low_water[i], bus_r.err_ovf[i], bus_r.err_udf[i]},
          {exp >= 1, exp <= 2, 1'b0, 1'b0});
    end
  endtask

  task automatic rand_cycle(input int cyc, input bit send_en);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      sent[i] += int'(vdrv[i]);
      ret[i]  += int'(ydrv[i]);
      if (vdrv[i]) due[i].push_back(cyc + int'($urandom_range(1, 5)));
    end
    check_rand(cyc);
    for (int i = 0; i < 4; i++) begin
      vdrv[i] = send_en && (7 - sent[i] + ret[i] >= 1) && ($urandom_range(0, 3) != 0);
      ydrv[i] = 1'b0;
      for (int k = 0; k < due[i].size(); k++) begin
        if (due[i][k] <= cyc) begin
          ydrv[i] = 1'b1;
          due[i].delete(k);
          break;
        end
      end
    end
    bus_r.valid = vdrv;
    bus_r.yummy = ydrv;
  endtask

  initial begin
    bus_d.valid = '0; bus_d.yummy = '0;
    bus_r.valid = '0; bus_r.yummy = '0;

    //   rst  v      y      c0 c1 spc    low    ovf    udf
    add(1'b1, 2'b00, 2'b00, 4, 4, 2'b11, 2'b00, 2'b00, 2'b00); // reset state
    add(1'b0, 2'b01, 2'b00, 3, 4, 2'b11, 2'b00, 2'b00, 2'b00); // four sends on ch0
    add(1'b0, 2'b01, 2'b00, 2, 4, 2'b11, 2'b00, 2'b00, 2'b00);
    add(1'b0, 2'b01, 2'b00, 1, 4, 2'b11, 2'b01, 2'b00, 2'b00);
    add(1'b0, 2'b01, 2'b00, 0, 4, 2'b10, 2'b01, 2'b00, 2'b00);
    add(1'b0, 2'b00, 2'b00, 0, 4, 2'b10, 2'b01, 2'b00, 2'b00);
    add(1'b0, 2'b01, 2'b00, 0, 4, 2'b10, 2'b01, 2'b00, 2'b00); // send with no credit
    add(1'b0, 2'b00, 2'b00, 0, 4, 2'b10, 2'b01, 2'b00, 2'b01);
    add(1'b0, 2'b00, 2'b01, 1, 4, 2'b11, 2'b01, 2'b00, 2'b01); // credit return from 0
    add(1'b0, 2'b00, 2'b00, 1, 4, 2'b11, 2'b01, 2'b00, 2'b01);
    add(1'b0, 2'b00, 2'b00, 1, 4, 2'b11, 2'b01, 2'b00, 2'b01);
    add(1'b0, 2'b01, 2'b01, 1, 4, 2'b11, 2'b01, 2'b00, 2'b01); // send+return together
    add(1'b0, 2'b00, 2'b00, 1, 4, 2'b11, 2'b01, 2'b00, 2'b01);
    add(1'b0, 2'b01, 2'b00, 0, 4, 2'b10, 2'b01, 2'b00, 2'b01);
    add(1'b1, 2'b01, 2'b00, 4, 4, 2'b11, 2'b00, 2'b00, 2'b00); // reset mid-traffic
    add(1'b0, 2'b00, 2'b00, 4, 4, 2'b11, 2'b00, 2'b00, 2'b00);
    add(1'b0, 2'b00, 2'b10, 4, 4, 2'b11, 2'b00, 2'b00, 2'b00); // return at full
    add(1'b0, 2'b00, 2'b00, 4, 4, 2'b11, 2'b00, 2'b10, 2'b00);

    for (int r = 0; r < tbl.size(); r++) begin
      reset = tbl[r].rst;
      bus_d.valid = tbl[r].v;
      bus_d.yummy = tbl[r].y;
      @(posedge clk); #1;
      chk($sformatf("row%0d cnt", r), int'(bus_d.credit_cnt), tbl[r].c1 * 8 + tbl[r].c0);
      chk($sformatf("row%0d spc", r), int'(bus_d.spc_avail), int'(tbl[r].spc));
      chk($sformatf("row%0d low", r), int'(bus_d.low_water), int'(tbl[r].low));
      chk($sformatf("row%0d ovf", r), int'(bus_d.err_ovf), int'(tbl[r].ovf));
      chk($sformatf("row%0d udf", r), int'(bus_d.err_udf), int'(tbl[r].udf));
    end
    bus_d.valid = '0; bus_d.yummy = '0;

    // Overflow flag stays set through idle time; ch0 remains clean.
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("ovf sticky %0d", k), int'(bus_d.err_ovf), 2);
      chk($sformatf("ovf hold cnt %0d", k), int'(bus_d.credit_cnt), 4 * 8 + 4);
    end

    // Random legal traffic on the 4-channel instance.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rand reset cnt", int'(bus_r.credit_cnt), 12'o7777);
    chk("rand reset spc", int'(bus_r.spc_avail), 15);
    chk("rand reset low", int'(bus_r.low_water), 0);
    for (int i = 0; i < 4; i++) begin sent[i] = 0; ret[i] = 0; end
    vdrv = '0; ydrv = '0;
    for (int c = 0; c < 400; c++) rand_cycle(c, 1'b1);
    for (int c = 400; c < 460; c++) rand_cycle(c, 1'b0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("drain ch%0d all credits back", i),
          int'((bus_r.credit_cnt >> (3 * i)) & 12'h7), 7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/credit_avail_vc.md
CREDIT_AVAIL_VC -- requirements
Module: credit_avail_vc

Interface
REQ-001 Parameter NUM_CH, default 2, number of independent virtual channels tracked.
REQ-002 Parameter BUFFER_SIZE, default 4, receiver buffer depth per channel (credits at reset); legal range 1..2^CNT_BITS-1.
REQ-003 Parameter CNT_BITS, default 3, credit counter width per channel.
REQ-004 Parameter LOW_MARK, default 1, low-water credit threshold; legal range 0..BUFFER_SIZE.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 valid  input  NUM_CH  bit i = one flit sent on channel i this cycle.
REQ-008 yummy  input  NUM_CH  bit i = one credit returned by receiver on channel i this cycle.
REQ-009 spc_avail  output  NUM_CH  bit i = channel i may send a flit this cycle.
REQ-010 low_water  output  NUM_CH  bit i = channel i effective credits <= LOW_MARK.
REQ-011 credit_cnt  output  NUM_CH*CNT_BITS  channel i effective credit count in bits [i*CNT_BITS +: CNT_BITS].
REQ-012 err_ovf  output  NUM_CH  sticky: credit returned while channel i already held BUFFER_SIZE credits.
REQ-013 err_udf  output  NUM_CH  sticky: flit sent while channel i held zero credits.

Function
REQ-014 Per channel i, the block SHALL hold count_f[i] (CNT_BITS), valid_f[i], yummy_f[i] (registered copies of valid[i], yummy[i]), and sticky error flops.
REQ-015 Channels SHALL be fully independent; no event on channel i SHALL affect channel j state or outputs.
REQ-016 Inputs valid/yummy SHALL take effect with one cycle of registration: event at edge N captured into valid_f/yummy_f, applied to count_f at edge N+1.
REQ-017 Effective count eff[i] = count_f[i] + yummy_f[i] - valid_f[i], computed in CNT_BITS+1 signed-safe arithmetic, clamped to 0..BUFFER_SIZE.
REQ-018 Next count: count_f[i] <= eff[i] each non-reset edge.
REQ-019 valid_f & yummy_f both set: count unchanged, no error.
REQ-020 count_f==BUFFER_SIZE with yummy_f & ~valid_f: count SHALL hold at BUFFER_SIZE and err_ovf[i] SHALL set.
REQ-021 count_f==0 with valid_f & ~yummy_f: count SHALL hold at 0 and err_udf[i] SHALL set.
REQ-022 spc_avail[i] SHALL be 1 iff eff[i] >= 1, i.e. count_f>=2, or yummy_f, or (count_f==1 & ~valid_f); for count_f==0 with valid_f and yummy_f set, spc_avail[i]=0 (eff=0).
REQ-023 spc_avail, low_water, credit_cnt SHALL depend only on flops (no combinational path from valid/yummy inputs).
REQ-024 credit_cnt[i] SHALL equal eff[i]; low_water[i] SHALL equal (eff[i] <= LOW_MARK).
REQ-025 Sending when spc_avail[i]=1 for any legal traffic pattern SHALL never set err_udf[i].
REQ-026 err_ovf/err_udf SHALL remain set until reset; new events SHALL not clear them.

Reset
REQ-027 During reset: count_f[i]=BUFFER_SIZE, valid_f=yummy_f=0, errors=0, all channels.
REQ-028 First cycle after reset: spc_avail=all ones, credit_cnt[i]=BUFFER_SIZE, low_water[i]=(BUFFER_SIZE<=LOW_MARK), err_*=0.
REQ-029 Reset asserted mid-traffic SHALL discard in-flight valid_f/yummy_f and restore REQ-027 values at the next edge.

Verification
REQ-030 Defaults; valid[0]=1 for 4 consecutive cycles, yummy=0 -> credit_cnt[0] 4,3,2,1,0 lagging one cycle; spc_avail[0]=0 in the cycle after 4th send registers; channel 1 stays at 4.
REQ-031 Channel 0 at 0 credits, yummy[0] pulse one cycle -> one cycle later spc_avail[0]=1, credit_cnt[0]=1, then holds 1.
REQ-032 Channel 0 at 1 credit, valid[0]=yummy[0]=1 same cycle -> credit_cnt[0] stays 1, spc_avail[0]=1, no error.
REQ-033 After reset, yummy[1]=1 one cycle -> err_ovf[1]=1 next cycle, credit_cnt[1] stays 4, err_ovf sticky for 10 idle cycles; err_ovf[0]=0.
REQ-034 Channel 0 at 0 credits, valid[0]=1 -> err_udf[0]=1, count stays 0; then reset -> all counts 4, errors 0.
REQ-035 Random legal traffic on NUM_CH=4, BUFFER_SIZE=7, CNT_BITS=3, sender obeys spc_avail, receiver returns credits 1-5 cycles after receipt -> no error flags, credit_cnt never exceeds 7, matches reference model every cycle.
